// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage with redirect draining and branch latching
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   stall[5:0]               ctrl stall vector; only bit0 (PC stage) affects fetch
//   flush, new_pc            exception redirect, highest priority
//   branch_flag_i,
//   branch_target_address_i  taken-branch strobe and target from ID
//   imem_req, imem_addr      instruction memory read request / address (= pc)
//   imem_ack, imem_rdata     read completion, data valid with ack
//   if_pc, if_inst           PC / instruction offered to IF/ID (zero when not ready)
//   stallreq_from_if         asks ctrl to stall while no instruction is ready
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_from_if
);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic        br_valid;
  logic [31:0] br_addr;
  logic [31:0] next_addr;
  logic        take_next;

  // The upper stall bits belong to later pipeline stages.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall[5:1];

  // A live branch strobe beats a remembered one, which beats sequential flow.
  assign next_addr = branch_flag_i ? branch_target_address_i :
                     br_valid      ? br_addr                 :
                                     pc + 32'd4;

  assign take_next = (state == ST_READY) && !flush && !stall[0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RST;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:   state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (flush)         state_nxt = imem_ack ? ST_FETCH : ST_DRAIN;
        else if (imem_ack) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (flush || !stall[0]) state_nxt = ST_FETCH;
      end
      ST_DRAIN: begin
        if (imem_ack) state_nxt = ST_FETCH;
      end
      default:  state_nxt = ST_RST;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= 32'd0;
      buf_pc     <= 32'd0;
      buf_inst   <= 32'd0;
      pend_valid <= 1'b0;
      pend_addr  <= 32'd0;
      br_valid   <= 1'b0;
      br_addr    <= 32'd0;
    end else begin
      case (state)
        ST_RST: begin
          pc         <= 32'd0;
          pend_valid <= 1'b0;
          br_valid   <= 1'b0;
        end
        ST_FETCH: begin
          if (flush) begin
            br_valid <= 1'b0;
            if (imem_ack) begin
              // Data returned for the old path is dropped.
              pc <= new_pc;
            end else begin
              // The bus request cannot be withdrawn; wait it out in DRAIN.
              pend_valid <= 1'b1;
              pend_addr  <= new_pc;
            end
          end else begin
            if (imem_ack) begin
              buf_pc   <= pc;
              buf_inst <= imem_rdata;
            end
            // The delay-slot fetch in flight finishes before the branch is taken.
            if (branch_flag_i) begin
              br_valid <= 1'b1;
              br_addr  <= branch_target_address_i;
            end
          end
        end
        ST_READY: begin
          if (flush) begin
            pc       <= new_pc;
            br_valid <= 1'b0;
          end else if (take_next) begin
            pc       <= next_addr;
            br_valid <= 1'b0;
          end else if (branch_flag_i) begin
            br_valid <= 1'b1;
            br_addr  <= branch_target_address_i;
          end
        end
        ST_DRAIN: begin
          if (flush) begin
            br_valid <= 1'b0;
            if (imem_ack) begin
              pc         <= new_pc;
              pend_valid <= 1'b0;
            end else begin
              pend_addr <= new_pc;
            end
          end else begin
            if (imem_ack) begin
              pend_valid <= 1'b0;
              if (pend_valid) pc <= pend_addr;
            end
            if (branch_flag_i) begin
              br_valid <= 1'b1;
              br_addr  <= branch_target_address_i;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic; reset forces every output low immediately.
  always_comb begin
    imem_req         = 1'b0;
    imem_addr        = 32'd0;
    if_pc            = 32'd0;
    if_inst          = 32'd0;
    stallreq_from_if = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH, ST_DRAIN: begin
          imem_req         = 1'b1;
          imem_addr        = pc;
          stallreq_from_if = 1'b1;
        end
        ST_READY: begin
          if_pc   = buf_pc;
          if_inst = buf_inst;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed and randomized checks of inst_fetch against a reference model
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_from_if;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .imem_req                (imem_req),
    .imem_addr               (imem_addr),
    .imem_ack                (imem_ack),
    .imem_rdata              (imem_rdata),
    .if_pc                   (if_pc),
    .if_inst                 (if_inst),
    .stallreq_from_if        (stallreq_from_if)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: "awake" is false for the one cycle after reset,
  // "holding" means an instruction is on offer, "draining" means a flushed
  // request is still outstanding, "br_pend" is a remembered taken branch.
  bit          m_awake, m_holding, m_draining, m_br_pend;
  logic [31:0] m_pc, m_redirect, m_br_target, m_insn_pc, m_insn_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_awake = 0; m_holding = 0; m_draining = 0; m_br_pend = 0;
      m_pc = 0; m_insn_pc = 0; m_insn_word = 0;
    end else if (!m_awake) begin
      m_awake = 1;
      m_pc = 0;
    end else if (m_holding) begin
      if (flush) begin
        m_pc = new_pc; m_holding = 0; m_br_pend = 0;
      end else if (!stall[0]) begin
        if (branch_flag_i) m_pc = branch_target_address_i;
        else if (m_br_pend) m_pc = m_br_target;
        else m_pc = m_pc + 4;
        m_holding = 0; m_br_pend = 0;
      end else if (branch_flag_i) begin
        m_br_pend = 1; m_br_target = branch_target_address_i;
      end
    end else begin
      if (flush) begin
        m_br_pend = 0;
        if (imem_ack) begin
          m_pc = new_pc; m_draining = 0;
        end else begin
          m_draining = 1; m_redirect = new_pc;
        end
      end else begin
        if (imem_ack) begin
          if (m_draining) begin
            m_pc = m_redirect; m_draining = 0;
          end else begin
            m_holding = 1; m_insn_pc = m_pc; m_insn_word = imem_rdata;
          end
        end
        if (branch_flag_i) begin
          m_br_pend = 1; m_br_target = branch_target_address_i;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [31:0] e_req, e_addr, e_pc, e_inst, e_stall;
    e_req = 0; e_addr = 0; e_pc = 0; e_inst = 0; e_stall = 0;
    if (!rst && m_awake) begin
      if (m_holding) begin
        e_pc = m_insn_pc; e_inst = m_insn_word;
      end else begin
        e_req = 1; e_addr = m_pc; e_stall = 1;
      end
    end
    check("imem_req",  {31'd0, imem_req},         e_req);
    check("imem_addr", imem_addr,                 e_addr);
    check("if_pc",     if_pc,                     e_pc);
    check("if_inst",   if_inst,                   e_inst);
    check("stallreq",  {31'd0, stallreq_from_if}, e_stall);
  endtask

  // One clock: drive at the falling edge, check shortly after, advance the model at the rising edge.
  task automatic cyc(input bit r, input bit s0, input bit f, input logic [31:0] np,
                     input bit b, input logic [31:0] t, input bit a, input logic [31:0] d);
    @(negedge clk);
    rst = r;
    stall = {5'($urandom_range(0, 31)), s0};
    flush = f;
    new_pc = np;
    branch_flag_i = b;
    branch_target_address_i = t;
    imem_ack = a;
    imem_rdata = d;
    #1 check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    m_awake = 0; m_holding = 0; m_draining = 0; m_br_pend = 0;
    m_pc = 0; m_redirect = 0; m_br_target = 0; m_insn_pc = 0; m_insn_word = 0;
    rst = 1; stall = 0; flush = 0; new_pc = 0; branch_flag_i = 0;
    branch_target_address_i = 0; imem_ack = 0; imem_rdata = 0;

    // Reset and sequential fetch
    cyc(1, 0, 0, 0, 0, 0, 1, 32'hDEAD0000);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_state_req", {31'd0, imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h11110000);
    check("first_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hA0A00000);
    check("seq_pc0", if_pc, 32'h0);
    check("seq_inst0", if_inst, 32'hA0A00000);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h0);
    check("seq_addr4", imem_addr, 32'h4);
    check("seq_stallreq", {31'd0, stallreq_from_if}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hA1A10004);
    check("seq_pc4", if_pc, 32'h4);
    check("seq_inst1", if_inst, 32'hA1A10004);

    // Hold while stalled in READY
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 1, 32'hBAD0BAD0);
      check("stall_hold_pc", if_pc, 32'h4);
      check("stall_no_req", {31'd0, imem_req}, 32'd0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("stall_release_addr", imem_addr, 32'h8);

    // Branch while fetching the delay slot
    cyc(0, 0, 0, 0, 1, 32'h100, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hA2A20008);
    check("br_slot_pc", if_pc, 32'h8);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("br_target_addr", imem_addr, 32'h100);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hA3A30100);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("br_cleared_addr", imem_addr, 32'h104);

    // Flush while a fetch is outstanding: drain first
    cyc(0, 0, 1, 32'h180, 0, 0, 0, 0);
    check("drain_addr", imem_addr, 32'h104);
    check("drain_nop", if_inst, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("drain_hold", imem_addr, 32'h104);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hFEEDFACE);
    check("drain_redirect", imem_addr, 32'h180);
    check("drain_discard", if_inst, 32'h0);

    // Flush and branch in the same READY cycle
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hA4A40180);
    cyc(0, 0, 1, 32'h200, 1, 32'h300, 0, 0);
    check("flush_over_branch", imem_addr, 32'h200);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hA5A50200);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("flush_clears_br", imem_addr, 32'h204);

    // pc+4 wraps at the top of the address space
    cyc(0, 0, 1, 32'hFFFFFFFC, 0, 0, 1, 32'h12345678);
    check("flush_ack_addr", imem_addr, 32'hFFFFFFFC);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hA6A6FFFC);
    check("wrap_pc", if_pc, 32'hFFFFFFFC);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset during DRAIN drops the pending redirect
    cyc(0, 0, 1, 32'h400, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_in_drain_req", {31'd0, imem_req}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h0);
    check("post_rst_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'hA7A70000);
    check("post_rst_pc", if_pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] np, tg;
      np = $urandom & 32'hFFFFFFFC;
      tg = $urandom & 32'hFFFFFFFC;
      if ($urandom_range(0, 9) == 0) np = 32'hFFFFFFFC;
      cyc($urandom_range(0, 199) == 0,
          $urandom_range(0, 99) < 35,
          $urandom_range(0, 99) < 8,
          np,
          $urandom_range(0, 99) < 15,
          tg,
          $urandom_range(0, 99) < 50,
          $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
